// File: rtl/conv_mac_pkg.sv
// -----------------------------------------------------------------------------
// conv_mac_pkg
// Shared definitions for the conv_mac_pipe multiply-accumulate slice:
//   - default width / depth constants
//   - beat_ctl_t : valid/last shadow that travels alongside the datapath
//   - tree_w()   : adder-tree result width for a given operand shape
//   - sat_hi()/sat_lo() : signed saturation bounds for a w-bit accumulator
//     (only used when CONV_MAC_SAT_EN is defined)
// -----------------------------------------------------------------------------
package conv_mac_pkg;

  localparam int DEF_A_W        = 8;
  localparam int DEF_B_W        = 16;
  localparam int DEF_LANES      = 4;
  localparam int DEF_ACC_W      = 32;
  localparam int DEF_MUL_STAGES = 2;

  typedef struct packed {
    logic valid;
    logic last;
  } beat_ctl_t;

  // Width that holds the sum of LANES full-precision signed products.
  function automatic int tree_w(input int a_w, input int b_w, input int lanes);
    return a_w + b_w + $clog2(lanes);
  endfunction

  // Bounds are produced in a wide signed type; callers cast down to w+1 bits.
  function automatic logic signed [127:0] sat_hi(input int w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] sat_lo(input int w);
    return -(128'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/conv_mac_pipe_if.sv
// -----------------------------------------------------------------------------
// conv_mac_pipe_if
// Beat-in / result-out handshake bundle for conv_mac_pipe.
//   in_valid/in_ready/in_a/in_b/in_last : operand beats (lane i at [i*W +: W])
//   out_valid/out_ready/out_data/out_ovf: dot-product results
// Modports: master = producer/consumer side, slave = the MAC block.
// Parameters must match the ones given to the conv_mac_pipe instance.
// -----------------------------------------------------------------------------
interface conv_mac_pipe_if
  import conv_mac_pkg::*;
#(
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int LANES = DEF_LANES,
  parameter int ACC_W = DEF_ACC_W
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*A_W-1:0]   in_a;
  logic [LANES*B_W-1:0]   in_b;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       out_data;
  logic                   out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/conv_mac_lane_mul.sv
// -----------------------------------------------------------------------------
// conv_mac_lane_mul
// One signed A_W x B_W multiplier followed by MUL_STAGES product registers.
//   ap_clk : clock
//   en     : pipeline advance (global stall when low)
//   a, b   : signed operands
//   p      : signed full-precision product, MUL_STAGES cycles after a/b
// -----------------------------------------------------------------------------
module conv_mac_lane_mul
  import conv_mac_pkg::*;
#(
  parameter int A_W        = DEF_A_W,
  parameter int B_W        = DEF_B_W,
  parameter int MUL_STAGES = DEF_MUL_STAGES
) (
  input  logic                    ap_clk,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [A_W+B_W-1:0] p
);
  localparam int P_W = A_W + B_W;

  logic signed [P_W-1:0] pipe [MUL_STAGES];

  // NOTE: datapath registers carry no reset; the valid shadow in the parent
  // decides whether their contents mean anything, so resetting them buys nothing.
  always_ff @(posedge ap_clk) begin
    if (en) begin
      // Operands are sign-extended first so the product is computed fully signed.
      pipe[0] <= P_W'(a) * P_W'(b);
      for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[MUL_STAGES-1];
endmodule

// File: rtl/conv_mac_pipe.sv
// -----------------------------------------------------------------------------
// conv_mac_pipe
// Pipelined signed dot-product engine: LANES products per beat, adder tree,
// accumulation across beats until an in_last beat closes the result.
//   ap_clk   : clock, rising edge
//   ap_rst_n : synchronous active-low reset
//   bus      : conv_mac_pipe_if.slave (beat input, result output)
// Pipeline: MUL_STAGES product regs -> tree reg -> accumulator/output reg.
// A held result (out_valid && !out_ready) stalls every stage.
// Optional macro CONV_MAC_SAT_EN: saturating accumulation with sticky
// per-result out_ovf; otherwise wrap modulo 2^ACC_W and out_ovf = 0.
// -----------------------------------------------------------------------------
module conv_mac_pipe
  import conv_mac_pkg::*;
#(
  parameter int A_W        = DEF_A_W,
  parameter int B_W        = DEF_B_W,
  parameter int LANES      = DEF_LANES,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int MUL_STAGES = DEF_MUL_STAGES
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  conv_mac_pipe_if.slave bus
);
  localparam int P_W    = A_W + B_W;
  localparam int TREE_W = tree_w(A_W, B_W, LANES);

  if (ACC_W < TREE_W) begin : g_bad_acc_w
    $error("conv_mac_pipe: ACC_W=%0d narrower than tree width %0d", ACC_W, TREE_W);
  end
  if (LANES < 1) begin : g_bad_lanes
    $error("conv_mac_pipe: LANES must be >= 1");
  end
  if (MUL_STAGES < 1 || MUL_STAGES > 4) begin : g_bad_stages
    $error("conv_mac_pipe: MUL_STAGES=%0d outside 1..4", MUL_STAGES);
  end

  logic en;
  logic accept;
  logic out_valid_q;
  logic signed [ACC_W-1:0] out_data_q;

  assign en           = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = en && ap_rst_n;
  assign accept       = bus.in_valid && bus.in_ready;

  // ---------------- multiplier lanes + control shadow ----------------
  logic signed [P_W-1:0] prod [LANES];
  beat_ctl_t             ctl  [MUL_STAGES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    conv_mac_lane_mul #(
      .A_W(A_W), .B_W(B_W), .MUL_STAGES(MUL_STAGES)
    ) u_mul (
      .ap_clk (ap_clk),
      .en     (en),
      .a      (bus.in_a[i*A_W +: A_W]),
      .b      (bus.in_b[i*B_W +: B_W]),
      .p      (prod[i])
    );
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < MUL_STAGES; i++) ctl[i] <= '0;
    end else if (en) begin
      ctl[0] <= '{valid: accept, last: accept && bus.in_last};
      for (int i = 1; i < MUL_STAGES; i++) ctl[i] <= ctl[i-1];
    end
  end

  // ---------------- adder tree ----------------
  logic signed [TREE_W-1:0] tree_sum;
  logic signed [TREE_W-1:0] tree_q;
  beat_ctl_t                tree_ctl;

  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) tree_sum = tree_sum + TREE_W'(prod[i]);
  end

  always_ff @(posedge ap_clk) begin
    if (en) tree_q <= tree_sum;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)  tree_ctl <= '0;
    else if (en)    tree_ctl <= ctl[MUL_STAGES-1];
  end

  // ---------------- accumulator ----------------
  logic signed [ACC_W-1:0] acc;
  logic                    first;
  logic signed [ACC_W-1:0] tree_ext;
  logic signed [ACC_W-1:0] acc_next;

  assign tree_ext = ACC_W'(tree_q);

`ifdef CONV_MAC_SAT_EN
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(sat_hi(ACC_W));
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(sat_lo(ACC_W));

  logic signed [ACC_W:0] sum_wide;
  logic                  ovf_acc;
  logic                  ovf_next;
  logic                  out_ovf_q;

  // One guard bit catches the overflow of a single add; the first beat of a
  // result always fits, so it can never saturate.
  always_comb begin
    sum_wide = (ACC_W+1)'(tree_ext);
    if (!first) sum_wide = sum_wide + (ACC_W+1)'(acc);
    acc_next = sum_wide[ACC_W-1:0];
    ovf_next = first ? 1'b0 : ovf_acc;
    if (sum_wide > SAT_HI) begin
      acc_next = SAT_HI[ACC_W-1:0];
      ovf_next = 1'b1;
    end else if (sum_wide < SAT_LO) begin
      acc_next = SAT_LO[ACC_W-1:0];
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ovf_acc   <= 1'b0;
      out_ovf_q <= 1'b0;
    end else if (en && tree_ctl.valid) begin
      ovf_acc <= ovf_next;
      if (tree_ctl.last) out_ovf_q <= ovf_next;
    end
  end

  assign bus.out_ovf = out_ovf_q;
`else
  always_comb begin
    acc_next = first ? tree_ext : acc + tree_ext;
  end

  assign bus.out_ovf = 1'b0;
`endif

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc         <= '0;
      first       <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      // en implies the previous result is gone (or was never there).
      out_valid_q <= tree_ctl.valid && tree_ctl.last;
      if (tree_ctl.valid) begin
        acc   <= acc_next;
        first <= tree_ctl.last;
        if (tree_ctl.last) out_data_q <= acc_next;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_conv_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_conv_mac_pipe
// Self-checking bench for conv_mac_pipe. Three instances cover different
// shapes: u0 (4 lanes, 2 mul stages, 32-bit acc), u1 (1 lane, 1 stage, 24-bit
// acc) and u2 (8 lanes, 4 stages, 40-bit acc). Expected results come from an
// integer dot-product model; honours CONV_MAC_SAT_EN.
// -----------------------------------------------------------------------------
module tb_conv_mac_pipe;

  logic ap_clk = 1'b0;
  logic ap_rst_n;
  always #5 ap_clk = ~ap_clk;

  conv_mac_pipe_if #(.A_W(8), .B_W(16), .LANES(4), .ACC_W(32)) if0 ();
  conv_mac_pipe_if #(.A_W(8), .B_W(16), .LANES(1), .ACC_W(24)) if1 ();
  conv_mac_pipe_if #(.A_W(8), .B_W(16), .LANES(8), .ACC_W(40)) if2 ();

  conv_mac_pipe #(.A_W(8), .B_W(16), .LANES(4), .ACC_W(32), .MUL_STAGES(2)) u0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if0.slave));
  conv_mac_pipe #(.A_W(8), .B_W(16), .LANES(1), .ACC_W(24), .MUL_STAGES(1)) u1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if1.slave));
  conv_mac_pipe #(.A_W(8), .B_W(16), .LANES(8), .ACC_W(40), .MUL_STAGES(4)) u2 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(if2.slave));

  // Per-instance drive and sample arrays, indexed by instance number.
  logic         v_d [3];
  logic         l_d [3];
  logic         r_d [3];
  logic [63:0]  a_d [3];
  logic [127:0] b_d [3];

  logic               rdy_s [3];
  logic               ov_s  [3];
  logic               ovf_s [3];
  logic signed [63:0] od_s  [3];

  assign if0.in_valid = v_d[0];  assign if0.in_last = l_d[0];  assign if0.out_ready = r_d[0];
  assign if0.in_a = a_d[0][31:0];  assign if0.in_b = b_d[0][63:0];
  assign if1.in_valid = v_d[1];  assign if1.in_last = l_d[1];  assign if1.out_ready = r_d[1];
  assign if1.in_a = a_d[1][7:0];   assign if1.in_b = b_d[1][15:0];
  assign if2.in_valid = v_d[2];  assign if2.in_last = l_d[2];  assign if2.out_ready = r_d[2];
  assign if2.in_a = a_d[2];        assign if2.in_b = b_d[2];

  assign rdy_s[0] = if0.in_ready;  assign ov_s[0] = if0.out_valid;  assign ovf_s[0] = if0.out_ovf;
  assign rdy_s[1] = if1.in_ready;  assign ov_s[1] = if1.out_valid;  assign ovf_s[1] = if1.out_ovf;
  assign rdy_s[2] = if2.in_ready;  assign ov_s[2] = if2.out_valid;  assign ovf_s[2] = if2.out_ovf;
  assign od_s[0] = {{32{if0.out_data[31]}}, if0.out_data};
  assign od_s[1] = {{40{if1.out_data[23]}}, if1.out_data};
  assign od_s[2] = {{24{if2.out_data[39]}}, if2.out_data};

`ifdef CONV_MAC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct { logic [63:0] a; logic [127:0] b; logic last; } beat_t;
  typedef struct { longint d; logic ovf; } res_t;

  beat_t beats [$];
  res_t  exp_q [$];

  // Reference model state: running dot product of the packet being queued.
  longint acc_m   = 0;
  bit     first_m = 1'b1;
  bit     ovf_m   = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lanes_of(input int s);
    case (s)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int accw_of(input int s);
    case (s)
      0:       return 32;
      1:       return 24;
      default: return 40;
    endcase
  endfunction

  function automatic longint beat_sum(input int s, input logic [63:0] a, input logic [127:0] b);
    longint t;
    logic signed [7:0]  x;
    logic signed [15:0] y;
    t = 0;
    for (int i = 0; i < lanes_of(s); i++) begin
      x = a[i*8 +: 8];
      y = b[i*16 +: 16];
      t = t + longint'(x) * longint'(y);
    end
    return t;
  endfunction

  function automatic logic [7:0] rand_a();
    case ($urandom_range(3))
      0:       return 8'h80;
      1:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rand_b();
    case ($urandom_range(3))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic push_exp(input longint d, input logic o);
    res_t r;
    r.d = d;
    r.ovf = o;
    exp_q.push_back(r);
  endtask

  // Queue a beat; with use_model the expected result is derived arithmetically.
  task automatic add_beat(input int s, input logic [63:0] a, input logic [127:0] b,
                          input logic last, input bit use_model);
    beat_t  bt;
    longint hi, lo, t;
    int     w;
    bt.a = a; bt.b = b; bt.last = last;
    beats.push_back(bt);
    if (use_model) begin
      w  = accw_of(s);
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      t  = beat_sum(s, a, b);
      if (first_m) begin
        acc_m = t;
        ovf_m = 1'b0;
      end else begin
        acc_m = acc_m + t;
        if (SAT) begin
          if (acc_m > hi) begin acc_m = hi; ovf_m = 1'b1; end
          else if (acc_m < lo) begin acc_m = lo; ovf_m = 1'b1; end
        end else begin
          acc_m = (acc_m <<< (64 - w)) >>> (64 - w);
        end
      end
      first_m = last;
      if (last) push_exp(acc_m, ovf_m);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      v_d[i] = 1'b0; l_d[i] = 1'b0; r_d[i] = 1'b1; a_d[i] = '0; b_d[i] = '0;
    end
  endtask

  // Streams the queued beats into instance s and scores every result.
  task automatic run(input int s, input int gap_pct, input int stall_pct, input int hold,
                     input int budget, output bit saw_block);
    int     cyc;
    bit     prev_hold;
    longint prev_d;
    res_t   e;
    cyc = 0; prev_hold = 1'b0; prev_d = 0; saw_block = 1'b0;
    while ((beats.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      @(negedge ap_clk);
      cyc++;
      if (beats.size() != 0 && $urandom_range(99) >= gap_pct) begin
        v_d[s] = 1'b1; a_d[s] = beats[0].a; b_d[s] = beats[0].b; l_d[s] = beats[0].last;
      end else begin
        v_d[s] = 1'b0; l_d[s] = 1'b0;
      end
      r_d[s] = (cyc > hold) && ($urandom_range(99) >= stall_pct);
      #1;
      if (prev_hold) begin
        check("hold_valid", ov_s[s], 1);
        check("hold_data", od_s[s], prev_d);
      end
      check("in_ready", rdy_s[s], !(ov_s[s] && !r_d[s]));
      if (!rdy_s[s]) saw_block = 1'b1;
      if (v_d[s] && rdy_s[s]) void'(beats.pop_front());
      if (ov_s[s] && r_d[s]) begin
        if (exp_q.size() == 0) begin
          check("extra_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("result_data", od_s[s], e.d);
          check("result_ovf", ovf_s[s], e.ovf);
        end
      end
      prev_hold = ov_s[s] && !r_d[s];
      prev_d    = od_s[s];
    end
    check("drain", beats.size() + exp_q.size(), 0);
    beats.delete();
    exp_q.delete();
    @(negedge ap_clk);
    idle_all();
  endtask

  initial begin
    bit blk;
    bit any_out;
    int n;
    logic [63:0]  ra;
    logic [127:0] rb;

    idle_all();
    ap_rst_n = 1'b0;

    // Reset state
    repeat (3) @(negedge ap_clk);
    #1;
    check("rst_in_ready", rdy_s[0], 0);
    check("rst_out_valid", ov_s[0], 0);
    check("rst_out_data", od_s[0], 0);
    check("rst_out_ovf", ovf_s[0], 0);
    check("rst_in_ready_u1", rdy_s[1], 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    check("ready_after_rst", rdy_s[0], 1);

    // Single-beat dot product, latency MUL_STAGES+2 = 4
    @(negedge ap_clk);
    v_d[0] = 1'b1; l_d[0] = 1'b1; r_d[0] = 1'b1;
    a_d[0] = 64'({8'd4, 8'd3, 8'd2, 8'd1});
    b_d[0] = 128'({16'd8, 16'd7, 16'd6, 16'd5});
    #1;
    check("lat_accept", rdy_s[0], 1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge ap_clk);
      v_d[0] = 1'b0; l_d[0] = 1'b0;
      #1;
      if (k < 4) begin
        check("lat_early", ov_s[0], 0);
      end else begin
        check("lat_valid", ov_s[0], 1);
        check("lat_data", od_s[0], 70);
        check("lat_ovf", ovf_s[0], 0);
      end
    end
    @(negedge ap_clk);
    #1;
    check("lat_consumed", ov_s[0], 0);

    // Three extreme beats: 3 * 4 * (-128 * 32767)
    for (int j = 0; j < 3; j++) add_beat(0, 64'({4{8'h80}}), 128'({4{16'h7FFF}}), j == 2, 1'b0);
    push_exp(3 * 4 * (-128 * 32767), 1'b0);
    run(0, 0, 0, 0, 200, blk);

    // Back-to-back packets with out_ready low for the first 10 cycles
    for (int p = 0; p < 5; p++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        for (int i = 0; i < 8; i++) begin ra[i*8 +: 8] = rand_a(); rb[i*16 +: 16] = rand_b(); end
        add_beat(0, ra, rb, j == n - 1, 1'b1);
      end
    end
    run(0, 0, 0, 10, 500, blk);
    check("stall_in_ready_dropped", blk, 1);

    // 24-bit, 1 lane: four beats of 127 x 32767 overflow the accumulator
    for (int j = 0; j < 4; j++) add_beat(1, 64'd127, 128'd32767, j == 3, 1'b0);
    if (SAT) push_exp(8388607, 1'b1);
    else     push_exp(-131580, 1'b0);
    run(1, 0, 0, 0, 200, blk);

    // Reset in the middle of a packet discards the partial dot product
    @(negedge ap_clk);
    v_d[0] = 1'b1; l_d[0] = 1'b0; a_d[0] = 64'({4{8'd3}}); b_d[0] = 128'({4{16'd9}});
    #1;
    check("rst_mid_beat1", rdy_s[0], 1);
    @(negedge ap_clk);
    #1;
    check("rst_mid_beat2", rdy_s[0], 1);
    @(negedge ap_clk);
    v_d[0] = 1'b0;
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    any_out = 1'b0;
    repeat (8) begin
      @(negedge ap_clk);
      #1;
      if (ov_s[0]) any_out = 1'b1;
    end
    check("rst_mid_no_output", any_out, 0);
    add_beat(0, 64'd2, 128'd3, 1'b1, 1'b0);
    push_exp(6, 1'b0);
    run(0, 0, 0, 0, 200, blk);

    // Random packets on every instance with random gaps and stalls
    for (int s = 0; s < 3; s++) begin
      for (int p = 0; p < 10; p++) begin
        n = ($urandom_range(3) == 0) ? 64 : $urandom_range(1, 24);
        for (int j = 0; j < n; j++) begin
          for (int i = 0; i < 8; i++) begin ra[i*8 +: 8] = rand_a(); rb[i*16 +: 16] = rand_b(); end
          add_beat(s, ra, rb, j == n - 1, 1'b1);
        end
      end
      run(s, 25, 30, 0, 20000, blk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
